// File: rtl/pipe_alu_pkg.sv
// rtl/pipe_alu_pkg.sv - opcode encoding shared by the pipelined ALU.
package pipe_alu_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

endpackage

// File: rtl/pipe_alu_stage.sv
// rtl/pipe_alu_stage.sv - one valid/data pipeline register with enable and async reset.
module pipe_alu_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - DEPTH-stage ADD/SUB/AND/XOR ALU with valid/ready flow control.
// Optional macro PIPE_ALU_SAT_EN saturates ADD overflow and SUB underflow.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag
);

  // Stage payload packs {flag, result}.
  logic             stg_valid [DEPTH+1];
  logic [WIDTH:0]   stg_data  [DEPTH+1];

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             flag_d;

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    res_d  = '0;
    flag_d = 1'b0;
    if (in_valid) begin
      case (op_e'(op))
        OP_ADD: begin
          flag_d = sum[WIDTH];
`ifdef PIPE_ALU_SAT_EN
          res_d  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
          res_d  = sum[WIDTH-1:0];
`endif
        end
        OP_SUB: begin
          // The extra top bit of the widened difference is the borrow (a < b).
          flag_d = diff[WIDTH];
`ifdef PIPE_ALU_SAT_EN
          res_d  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
          res_d  = diff[WIDTH-1:0];
`endif
        end
        OP_AND:  res_d = in_a & in_b;
        OP_XOR:  res_d = in_a ^ in_b;
        default: res_d = '0;
      endcase
    end
  end

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = {flag_d, res_d};

  // Single shared enable: every stage moves or every stage holds.
  assign in_ready = !out_valid || out_ready;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    pipe_alu_stage #(.W(WIDTH + 1)) u_stage (
      .clk     (sysclk),
      .rst_n   (rst_n),
      .en      (in_ready),
      .valid_i (stg_valid[s]),
      .data_i  (stg_data[s]),
      .valid_o (stg_valid[s+1]),
      .data_o  (stg_data[s+1])
    );
  end

  assign out_valid = stg_valid[DEPTH];
  assign out       = stg_data[DEPTH][WIDTH-1:0];
  assign flag      = stg_data[DEPTH][WIDTH];

endmodule

// File: tb/tb_pipe_alu.sv
// tb/tb_pipe_alu.sv - directed self-checking bench for pipe_alu (WIDTH=4, DEPTH=2).
module tb_pipe_alu;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic       flag;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_alu #(.WIDTH(4), .DEPTH(2)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag      (flag)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    op       = o;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op       = 2'd3;
    in_a     = 4'hf;
    in_b     = 4'hf;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    #12;
    n_checks++;
    if (out !== 4'd0 || flag !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: out=%0d flag=%b out_valid=%b in_ready=%b, want 0 0 0 1",
               out, flag, out_valid, in_ready);
    end
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_after_reset: cycle %0d out_valid=%b in_ready=%b, want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  // Presents one operation for a single cycle and checks it surfaces two cycles later, once.
  task automatic run_op(input string name, input logic [1:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp_out, input logic exp_flag);
    out_ready = 1'b1;
    drive(o, a, b);
    step();
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: out_valid=%b after 1 cycle, want 0", name, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== exp_out || flag !== exp_flag) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out=%0d flag=%b, want 1 %0d %b",
               name, out_valid, out, flag, exp_out, exp_flag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_once: out_valid=%b a cycle later, want 0", name, out_valid);
    end
  endtask

  task automatic test_single_add();
    run_op("add_1_0", 2'd0, 4'd1, 4'd0, 4'd1, 1'b0);
  endtask

  task automatic test_arith();
`ifdef PIPE_ALU_SAT_EN
    run_op("add_9_8",   2'd0, 4'd9,  4'd8,  4'd15, 1'b1);
    run_op("sub_3_5",   2'd1, 4'd3,  4'd5,  4'd0,  1'b1);
    run_op("add_15_15", 2'd0, 4'd15, 4'd15, 4'd15, 1'b1);
`else
    run_op("add_9_8",   2'd0, 4'd9,  4'd8,  4'd1,  1'b1);
    run_op("sub_3_5",   2'd1, 4'd3,  4'd5,  4'd14, 1'b1);
    run_op("add_15_15", 2'd0, 4'd15, 4'd15, 4'd14, 1'b1);
`endif
    run_op("sub_5_3",   2'd1, 4'd5,  4'd3,  4'd2,  1'b0);
    run_op("sub_7_7",   2'd1, 4'd7,  4'd7,  4'd0,  1'b0);
    run_op("and_6_3",   2'd2, 4'd6,  4'd3,  4'd2,  1'b0);
    run_op("xor_15_5",  2'd3, 4'd15, 4'd5,  4'd10, 1'b0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(2'd2, 4'd12, 4'd10);
    step();
    drive(2'd3, 4'd12, 4'd10);
    step();
    drive(2'd0, 4'd7, 4'd7);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 4'd8 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall: out_valid=%b out=%0d in_ready=%b, want 1 8 0",
               out_valid, out, in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 4'd8 || flag !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: out_valid=%b out=%0d flag=%b in_ready=%b, want 1 8 0 0",
               out_valid, out, flag, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out !== 4'd8) begin
      n_fail++;
      $display("FAIL b2b_release: in_ready=%b out=%0d, want 1 8", in_ready, out);
    end
    step();
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 4'd6 || flag !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_xor: out_valid=%b out=%0d flag=%b, want 1 6 0", out_valid, out, flag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 4'd14 || flag !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: out_valid=%b out=%0d flag=%b, want 1 14 0", out_valid, out, flag);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    drive(2'd0, 4'd1, 4'd1);
    step();
    drive(2'd0, 4'd3, 4'd3);
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out !== 4'd0 || flag !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_async: out_valid=%b out=%0d flag=%b in_ready=%b, want 0 0 0 1",
               out_valid, out, flag, in_ready);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale: cycle %0d out_valid=%b out=%0d, want no result",
                 i, out_valid, out);
      end
    end
    run_op("add_2_2", 2'd0, 4'd2, 4'd2, 4'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_arith();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 4: operand and result width in bits, legal range 2..32.
REQ-003 Parameter DEPTH, default 2: number of pipeline stages (latency in cycles), legal range 1..4.
REQ-004 Port sysclk, input, 1 bit: clock, rising edge active.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: an operation is presented this cycle.
REQ-007 Port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-008 Port op, input, 2 bits: opcode; 0 ADD, 1 SUB (a-b), 2 AND, 3 XOR.
REQ-009 Port in_a, input, WIDTH bits: operand A, unsigned.
REQ-010 Port in_b, input, WIDTH bits: operand B, unsigned.
REQ-011 Port out_valid, output, 1 bit: out and flag hold a result.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port out, output, WIDTH bits: result.
REQ-014 Port flag, output, 1 bit: carry for ADD, borrow for SUB, 0 for AND and XOR.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready, combinationally; the whole pipeline advances together when in_ready is 1 and holds every stage when it is 0.
REQ-017 The result SHALL be computed into stage 1; stages 2..DEPTH SHALL be pure delay. The result appears on out exactly DEPTH advancing cycles after acceptance.
REQ-018 Each stage SHALL carry a valid bit; a cycle without acceptance inserts a bubble, so throughput is one operation per cycle.
REQ-019 ADD SHALL compute the sum in WIDTH+1 bits: out = sum[WIDTH-1:0] and flag = sum[WIDTH].
REQ-020 SUB SHALL compute out = (a-b) mod 2^WIDTH, with flag = (a < b).
REQ-021 While out_valid is 1 and out_ready is 0, out, flag and out_valid SHALL remain stable.
REQ-022 Results SHALL leave in acceptance order; no operation is dropped or duplicated.
REQ-023 Simultaneous acceptance and output consumption in one cycle SHALL both take effect.
REQ-024 Opcodes SHALL be decoded only when accepted; the op, in_a and in_b values while in_valid is 0 are ignored.

Reset
REQ-025 While rst_n is 0, all stage valid bits, out, flag and out_valid SHALL be 0 immediately (asynchronous).
REQ-026 An assertion of rst_n mid-operation SHALL discard all in-flight operations; no result from before the reset appears afterwards.
REQ-027 in_ready SHALL read 1 during and after reset.

Configuration
REQ-028 When the macro PIPE_ALU_SAT_EN is defined, ADD overflow SHALL produce out = 2^WIDTH-1 and SUB underflow SHALL produce out = 0; flag is unchanged by saturation.
REQ-029 When PIPE_ALU_SAT_EN is undefined, ADD and SUB SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be present.

Structure
REQ-030 The package pipe_alu_pkg SHALL hold the opcode enum typedef (OP_ADD, OP_SUB, OP_AND, OP_XOR) and the opcode width constant.
REQ-031 One sub-module, pipe_alu_stage, SHALL implement a single valid/data register stage with enable and async reset; pipe_alu SHALL instantiate it DEPTH times using generate.

Verification (WIDTH=4, DEPTH=2)
REQ-032 Hold rst_n=0 -> out=0, flag=0, out_valid=0, in_ready=1; release reset, idle 5 cycles -> out_valid stays 0.
REQ-033 ADD a=1, b=0 for one cycle, out_ready=1 -> out_valid=1 with out=1, flag=0 exactly 2 cycles later, for one cycle only.
REQ-034 ADD 9+8 -> out=1, flag=1 (with PIPE_ALU_SAT_EN: out=15, flag=1); SUB 3-5 -> out=14, flag=1 (with PIPE_ALU_SAT_EN: out=0, flag=1).
REQ-035 Back-to-back AND 12&10, then XOR 12^10, then ADD 7+7, with out_ready=0 -> in_ready falls once out_valid=1; out holds 8; then raising out_ready gives 8, 6 and 14 (flag 0) on consecutive cycles.
REQ-036 Accept 2 operations, pulse rst_n low for half a cycle mid-pipeline -> out_valid=0 at once and no stale result ever appears; a new ADD 2+2 then returns 4 after 2 cycles.
